c7bicu_fetch_resp: RTL and testbench
====================================

Name: c7bicu_fetch_resp

Overview:
- Responder end of the IFU↔ICU fetch handshake (ifu_icu_req_ic1 / icu_ifu_ack_ic1 / icu_ifu_data_valid_ic2).
- Accepts one fetch request at a time, acknowledges it, and issues a read on the instruction memory bus.
- Returns one 32-bit instruction with a data-valid pulse.
- Sits between the fetch control logic and the instruction memory port.

Parameters:
- ADDR_W, 32, fetch/memory address width.
- NOP_INST, 32'h03400000, LoongArch nop returned in place of data on a bus error.

Ports:
- clk  in  1  clock; single clock domain.
- resetn  in  1  synchronous, active-low reset.
- ifu_icu_req_ic1  in  1  fetch request; held high by the requester until ack.
- ifu_icu_addr_ic1  in  ADDR_W  fetch address; valid while req is high.
- icu_ifu_ack_ic1  out  1  request accepted (one-cycle pulse).
- icu_ifu_data_valid_ic2  out  1  instruction valid (one-cycle pulse).
- icu_ifu_data_ic2  out  32  instruction word.
- icu_ifu_err_ic2  out  1  bus error for this fetch; qualified by data_valid.
- icu_mem_req  out  1  memory read request; held until gnt.
- icu_mem_addr  out  ADDR_W  8-byte-aligned line address (addr[2:0]=0).
- mem_icu_gnt  in  1  memory accepted the request.
- mem_icu_rvalid  in  1  read data valid.
- mem_icu_rdata  in  64  two-instruction line.
- mem_icu_rerr  in  1  read error; qualified by rvalid.
- icu_inv  in  1  invalidate line buffer (ibar); ignored unless the feature is compiled in.

Behaviour:
- FSM states: IDLE, BUS, WAIT, RESP. Reset (resetn=0 at clk edge) → IDLE. All registered outputs reset to 0; data output resets to 0.
- Ack is combinational: icu_ifu_ack_ic1 = ifu_icu_req_ic1 & (state==IDLE) & resetn.
  - Asserted for exactly one cycle per request. No ack outside IDLE.
- On ack: latch addr[ADDR_W-1:2]; go to BUS. addr[1:0] are ignored.
- BUS:
  - icu_mem_req=1, icu_mem_addr = {latched addr[ADDR_W-1:3], 3'b0}.
  - On mem_icu_gnt → WAIT. A gnt with rvalid in the same cycle is legal and goes straight to capture.
- WAIT: on mem_icu_rvalid, capture data and go to RESP.
  - Data word = rdata[63:32] if addr[2] else rdata[31:0].
  - If rerr: data=NOP_INST and err=1.
- RESP:
  - icu_ifu_data_valid_ic2=1 for one cycle, with data and err.
  - Next state IDLE; a req present in the RESP cycle is acked the following cycle.
- Minimum latency, no feature:
  - ack at t, mem_req at t+1 (gnt at t+1), rvalid at t+2, data_valid at t+3.
  - Arbitrary gnt/rvalid wait states are tolerated.
- Exactly one data_valid per ack, even if the requester has flushed. Cancellation is the requester's job; the responder never drops a response.
- Data/err outputs hold their values outside the data_valid pulse. They are not cleared.
- rvalid in IDLE/BUS/RESP (protocol violation) is ignored.
- Reset mid-operation: FSM returns to IDLE and mem_req drops immediately. The memory side shares the reset, so any in-flight read is abandoned.
- Only one transaction is outstanding at a time; no queueing.

Optional Feature:
- Macro C7BICU_LINEBUF_EN: one-line buffer (tag = addr[ADDR_W-1:3], valid bit, 64-bit data).
  - Filled on every error-free rvalid.
  - On ack with a valid tag match: skip BUS/WAIT and go to RESP, so data_valid comes at t+1 with no bus activity.
  - Valid is cleared by reset, by icu_inv, and by an rerr response.
  - icu_inv together with an ack: the invalidate wins and the request goes to the bus.
  - If icu_inv is asserted while a fill is in flight, that fill does not set valid.
- Without the macro: icu_inv is unused and every fetch goes to the bus.

Decomposition:
- Shared package: FSM state encoding (2-bit localparams), NOP_INST constant, line width 64.
- Sub-module c7bicu_linebuf (tag/valid/data registers, hit compare, word select).
  - Instantiated only under C7BICU_LINEBUF_EN.
  - Word select otherwise stays inline.

Test Plan:
- Single fetch: req at t, addr 0x1C000004; gnt at t+1, rvalid at t+2 with rdata 64'hAAAA0001_BBBB0002 → ack at t, mem_addr 0x1C000000, data_valid at t+3, data 32'hAAAA0001, err 0.
- Stalled bus: gnt delayed 3 cycles, rvalid delayed 4 cycles → mem_req held the whole time, exactly one ack and one data_valid, and no second ack while busy.
- Error: rvalid with rerr=1 → data_valid with data 32'h03400000 and err 1; with the feature, the next fetch to the same line goes to the bus.
- Back-to-back: new req raised the cycle after data_valid → acked immediately, bus address correct, no lost or duplicated pulses across 16 sequential fetches from 0x1C000000.
- Reset mid-WAIT: resetn low for 1 cycle → mem_req=0, ack=0, data_valid=0 next cycle; a late rvalid is ignored, and a fresh req is acked normally.
- With C7BICU_LINEBUF_EN: fetch 0x1C000000, then 0x1C000004 → second fetch has data_valid at ack+1 with no mem_req; after icu_inv, a fetch to 0x1C000004 goes to the bus.

Source files
------------

// File: rtl/c7bicu_fetch_resp_pkg.sv
// rtl/c7bicu_fetch_resp_pkg.sv - shared state encoding, line constants and word-select helper for the fetch responder
package c7bicu_fetch_resp_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUS  = 2'd1;
  localparam logic [1:0] ST_WAIT = 2'd2;
  localparam logic [1:0] ST_RESP = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE = ST_IDLE,
    S_BUS  = ST_BUS,
    S_WAIT = ST_WAIT,
    S_RESP = ST_RESP
  } state_e;

  localparam int          LINE_W       = 64;
  localparam logic [31:0] NOP_INST_DEF = 32'h03400000;

  // A line holds two instructions; address bit 2 picks the upper one.
  function automatic logic [31:0] sel_word(input logic [LINE_W-1:0] line, input logic hi);
    return hi ? line[LINE_W-1:32] : line[31:0];
  endfunction

endpackage

// File: rtl/c7bicu_linebuf.sv
// rtl/c7bicu_linebuf.sv - single-line instruction buffer with tag compare and word select
module c7bicu_linebuf
  import c7bicu_fetch_resp_pkg::*;
#(
  parameter int TAG_W = 29
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              inv,
  input  logic              fill_start,
  input  logic              fill_en,
  input  logic              fill_err,
  input  logic [TAG_W-1:0]  fill_tag,
  input  logic [LINE_W-1:0] fill_data,
  input  logic [TAG_W-1:0]  lookup_tag,
  input  logic              lookup_hi,
  output logic              hit,
  output logic [31:0]       hit_word
);

  logic              valid_q;
  logic              kill_q;
  logic [TAG_W-1:0]  tag_q;
  logic [LINE_W-1:0] data_q;

  // kill_q remembers an invalidate seen after the current miss left for the bus,
  // so that stale data returning later never becomes valid.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      valid_q <= 1'b0;
      kill_q  <= 1'b0;
      tag_q   <= '0;
      data_q  <= '0;
    end else begin
      if (fill_start) kill_q <= 1'b0;
      if (inv)        kill_q <= 1'b1;
      if (inv || (fill_en && fill_err)) begin
        valid_q <= 1'b0;
      end else if (fill_en && !kill_q) begin
        valid_q <= 1'b1;
        tag_q   <= fill_tag;
        data_q  <= fill_data;
      end
    end
  end

  assign hit      = valid_q && (tag_q == lookup_tag);
  assign hit_word = sel_word(data_q, lookup_hi);

endmodule

// File: rtl/c7bicu_fetch_resp.sv
// rtl/c7bicu_fetch_resp.sv - IFU fetch responder issuing one instruction-memory read per request
// Optional one-line buffer compiled in with C7BICU_LINEBUF_EN.
module c7bicu_fetch_resp
  import c7bicu_fetch_resp_pkg::*;
#(
  parameter int          ADDR_W   = 32,
  parameter logic [31:0] NOP_INST = NOP_INST_DEF
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              ifu_icu_req_ic1,
  input  logic [ADDR_W-1:0] ifu_icu_addr_ic1,
  output logic              icu_ifu_ack_ic1,
  output logic              icu_ifu_data_valid_ic2,
  output logic [31:0]       icu_ifu_data_ic2,
  output logic              icu_ifu_err_ic2,
  output logic              icu_mem_req,
  output logic [ADDR_W-1:0] icu_mem_addr,
  input  logic              mem_icu_gnt,
  input  logic              mem_icu_rvalid,
  input  logic [63:0]       mem_icu_rdata,
  input  logic              mem_icu_rerr,
  input  logic              icu_inv
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:2] addr_q;
  logic [31:0]       data_q;
  logic              err_q;
  logic              ack;
  logic              capture;
  logic              hit_take;
  logic [31:0]       hit_word;
  logic [31:0]       cap_word;

  assign ack     = ifu_icu_req_ic1 & (state_q == S_IDLE) & resetn;
  // A grant and read data may arrive together, so BUS can capture directly.
  assign capture = mem_icu_rvalid & (((state_q == S_BUS) & mem_icu_gnt) | (state_q == S_WAIT));
  assign cap_word = mem_icu_rerr ? NOP_INST : sel_word(mem_icu_rdata, addr_q[2]);

`ifdef C7BICU_LINEBUF_EN
  logic lb_hit;

  // An invalidate in the ack cycle beats a hit and sends the fetch to the bus.
  assign hit_take = ack & lb_hit & ~icu_inv;

  c7bicu_linebuf #(
    .TAG_W(ADDR_W-3)
  ) u_linebuf (
    .clk        (clk),
    .resetn     (resetn),
    .inv        (icu_inv),
    .fill_start (ack & ~hit_take),
    .fill_en    (capture),
    .fill_err   (mem_icu_rerr),
    .fill_tag   (addr_q[ADDR_W-1:3]),
    .fill_data  (mem_icu_rdata),
    .lookup_tag (ifu_icu_addr_ic1[ADDR_W-1:3]),
    .lookup_hi  (ifu_icu_addr_ic1[2]),
    .hit        (lb_hit),
    .hit_word   (hit_word)
  );
`else
  logic unused_inv;

  assign hit_take   = 1'b0;
  assign hit_word   = '0;
  assign unused_inv = icu_inv;
`endif

  logic unused_addr_lsb;
  assign unused_addr_lsb = ^ifu_icu_addr_ic1[1:0];

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      data_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (ack) addr_q <= ifu_icu_addr_ic1[ADDR_W-1:2];
      if (hit_take) begin
        data_q <= hit_word;
        err_q  <= 1'b0;
      end else if (capture) begin
        data_q <= cap_word;
        err_q  <= mem_icu_rerr;
      end
    end
  end

  always_comb begin
    state_d                = state_q;
    icu_mem_req            = 1'b0;
    icu_ifu_data_valid_ic2 = 1'b0;
    case (state_q)
      S_IDLE: if (ack) state_d = hit_take ? S_RESP : S_BUS;
      S_BUS: begin
        icu_mem_req = 1'b1;
        if (mem_icu_gnt) state_d = mem_icu_rvalid ? S_RESP : S_WAIT;
      end
      S_WAIT: if (mem_icu_rvalid) state_d = S_RESP;
      S_RESP: begin
        icu_ifu_data_valid_ic2 = 1'b1;
        state_d                = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign icu_ifu_ack_ic1  = ack;
  assign icu_mem_addr     = {addr_q[ADDR_W-1:3], 3'b000};
  assign icu_ifu_data_ic2 = data_q;
  assign icu_ifu_err_ic2  = err_q;

endmodule

// File: tb/tb_c7bicu_fetch_resp.sv
// tb/tb_c7bicu_fetch_resp.sv - scoreboard bench for the fetch responder with a wait-state memory model
module tb_c7bicu_fetch_resp;

  localparam logic [31:0] NOP = 32'h03400000;

  logic        clk = 1'b0;
  logic        resetn;
  logic        ifu_icu_req_ic1;
  logic [31:0] ifu_icu_addr_ic1;
  logic        icu_ifu_ack_ic1;
  logic        icu_ifu_data_valid_ic2;
  logic [31:0] icu_ifu_data_ic2;
  logic        icu_ifu_err_ic2;
  logic        icu_mem_req;
  logic [31:0] icu_mem_addr;
  logic        mem_icu_gnt;
  logic        mem_icu_rvalid;
  logic [63:0] mem_icu_rdata;
  logic        mem_icu_rerr;
  logic        icu_inv;

  c7bicu_fetch_resp dut (
    .clk                    (clk),
    .resetn                 (resetn),
    .ifu_icu_req_ic1        (ifu_icu_req_ic1),
    .ifu_icu_addr_ic1       (ifu_icu_addr_ic1),
    .icu_ifu_ack_ic1        (icu_ifu_ack_ic1),
    .icu_ifu_data_valid_ic2 (icu_ifu_data_valid_ic2),
    .icu_ifu_data_ic2       (icu_ifu_data_ic2),
    .icu_ifu_err_ic2        (icu_ifu_err_ic2),
    .icu_mem_req            (icu_mem_req),
    .icu_mem_addr           (icu_mem_addr),
    .mem_icu_gnt            (mem_icu_gnt),
    .mem_icu_rvalid         (mem_icu_rvalid),
    .mem_icu_rdata          (mem_icu_rdata),
    .mem_icu_rerr           (mem_icu_rerr),
    .icu_inv                (icu_inv)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  logic [32:0] exp_q[$];
  logic [31:0] exp_addr_q[$];

  int ack_cnt = 0, resp_cnt = 0, mreq_rises = 0, mreq_cycles = 0;
  int t_dv = 0, t_mreq = 0;
  bit mreq_prev = 1'b0;

  int gnt_dly = 0, rv_dly = 0;
  bit same_cyc = 1'b0, rerr_cfg = 1'b0, inject_rv = 1'b0;

  function automatic logic [63:0] line_of(input logic [31:0] a);
    logic [31:0] base;
    base = {a[31:3], 3'b000};
    if (base == 32'h1C000000) return 64'hAAAA0001_BBBB0002;
    return {base ^ 32'h5A5A0004, base ^ 32'hA5A50000};
  endfunction

  function automatic logic [31:0] word_of(input logic [31:0] a);
    logic [63:0] l;
    l = line_of(a);
    return a[2] ? l[63:32] : l[31:0];
  endfunction

  // Memory model: grants after gnt_dly cycles of mem_req, returns data rv_dly cycles after grant.
  initial begin : mem_model
    int          m_cnt;
    int          m_phase;
    logic [31:0] m_addr;
    logic [31:0] ea;
    m_cnt = 0; m_phase = 0; m_addr = '0;
    mem_icu_gnt = 1'b0; mem_icu_rvalid = 1'b0; mem_icu_rerr = 1'b0; mem_icu_rdata = '0;
    forever begin
      @(posedge clk); #2;
      mem_icu_gnt = 1'b0; mem_icu_rvalid = 1'b0; mem_icu_rerr = 1'b0; mem_icu_rdata = '0;
      if (!resetn) begin
        m_phase = 0; m_cnt = 0;
      end else if (inject_rv) begin
        inject_rv = 1'b0;
        mem_icu_rvalid = 1'b1;
        mem_icu_rdata = {$urandom, $urandom};
      end else if (m_phase == 0) begin
        if (icu_mem_req) begin
          if (m_cnt < gnt_dly) m_cnt++;
          else begin
            mem_icu_gnt = 1'b1; m_addr = icu_mem_addr; m_cnt = 0;
            checks++;
            if (exp_addr_q.size() == 0) begin
              errors++;
              $display("FAIL mem_addr: bus request to %h, required no bus request", m_addr);
            end else begin
              ea = exp_addr_q.pop_front();
              if (m_addr !== ea) begin
                errors++;
                $display("FAIL mem_addr: got %h, required %h", m_addr, ea);
              end
            end
            if (same_cyc) begin
              mem_icu_rvalid = 1'b1; mem_icu_rdata = line_of(m_addr); mem_icu_rerr = rerr_cfg;
            end else m_phase = 1;
          end
        end
      end else begin
        if (m_cnt < rv_dly) m_cnt++;
        else begin
          mem_icu_rvalid = 1'b1; mem_icu_rdata = line_of(m_addr); mem_icu_rerr = rerr_cfg;
          m_phase = 0; m_cnt = 0;
        end
      end
    end
  end

  // Monitor: counts pulses and pops the response scoreboard on every data_valid.
  initial begin : monitor
    logic [32:0] e;
    forever begin
      @(negedge clk);
      if (icu_ifu_ack_ic1 === 1'b1) ack_cnt++;
      if (icu_mem_req === 1'b1) begin
        mreq_cycles++;
        if (!mreq_prev) begin mreq_rises++; t_mreq = cyc; end
      end
      mreq_prev = (icu_mem_req === 1'b1);
      if (icu_ifu_data_valid_ic2 === 1'b1) begin
        resp_cnt++; t_dv = cyc;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL resp_extra: data_valid with %h/%b, required no response", icu_ifu_data_ic2, icu_ifu_err_ic2);
        end else begin
          e = exp_q.pop_front();
          if ({icu_ifu_data_ic2, icu_ifu_err_ic2} !== e) begin
            errors++;
            $display("FAIL resp_data: got %h err %b, required %h err %b",
                     icu_ifu_data_ic2, icu_ifu_err_ic2, e[32:1], e[0]);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1);
  end

  // inv_mode: 0 none, 1 invalidate alongside the request, 2 invalidate while the fill is in flight.
  task automatic fetch(input logic [31:0] a, input bit exp_bus, input int exp_lat,
                       input int inv_mode, input logic rerr_now, output int t_ack);
    logic [31:0] d;
    int acks0, rises0, resp0;
    bit got;
    d = rerr_now ? NOP : word_of(a);
    t_ack = -1;
    exp_q.push_back({d, rerr_now});
    if (exp_bus) exp_addr_q.push_back({a[31:3], 3'b000});
    rerr_cfg = rerr_now;
    acks0 = ack_cnt; rises0 = mreq_rises; resp0 = resp_cnt;
    @(posedge clk); #1;
    ifu_icu_req_ic1 = 1'b1; ifu_icu_addr_ic1 = a; icu_inv = (inv_mode == 1);
    got = 1'b0;
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge clk); #1;
      if (icu_ifu_ack_ic1 === 1'b1) begin got = 1'b1; t_ack = cyc; end
    end
    @(posedge clk); #1;
    ifu_icu_req_ic1 = 1'b0; icu_inv = (inv_mode == 2);
    if (inv_mode == 2) begin @(posedge clk); #1; icu_inv = 1'b0; end
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL ack_%h: got no ack in 50 cycles, required ack", a);
      exp_q.delete(); exp_addr_q.delete();
      return;
    end
    got = 1'b0;
    for (int i = 0; i < 100 && !got; i++) begin
      if (resp_cnt != resp0) got = 1'b1;
      else begin @(negedge clk); #1; end
    end
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL dv_%h: got no data_valid in 100 cycles, required one", a);
      exp_q.delete(); exp_addr_q.delete();
      return;
    end
    checks++;
    if (t_dv - t_ack != exp_lat) begin
      errors++;
      $display("FAIL latency_%h: got %0d, required %0d", a, t_dv - t_ack, exp_lat);
    end
    checks++;
    if (mreq_rises - rises0 != (exp_bus ? 1 : 0)) begin
      errors++;
      $display("FAIL bus_use_%h: got %0d bus requests, required %0d", a, mreq_rises - rises0, exp_bus ? 1 : 0);
    end
    checks++;
    if (ack_cnt - acks0 != 1) begin
      errors++;
      $display("FAIL ack_count_%h: got %0d, required 1", a, ack_cnt - acks0);
    end
  endtask

  task automatic test_reset();
    resetn = 1'b0; ifu_icu_req_ic1 = 1'b1; ifu_icu_addr_ic1 = 32'h1C000000; icu_inv = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    checks++;
    if (icu_ifu_ack_ic1 !== 1'b0) begin errors++; $display("FAIL reset_ack: got %b, required 0", icu_ifu_ack_ic1); end
    checks++;
    if (icu_mem_req !== 1'b0) begin errors++; $display("FAIL reset_mem_req: got %b, required 0", icu_mem_req); end
    checks++;
    if (icu_ifu_data_valid_ic2 !== 1'b0) begin errors++; $display("FAIL reset_dv: got %b, required 0", icu_ifu_data_valid_ic2); end
    checks++;
    if ({icu_ifu_data_ic2, icu_ifu_err_ic2} !== 33'h0) begin
      errors++; $display("FAIL reset_data: got %h/%b, required 0/0", icu_ifu_data_ic2, icu_ifu_err_ic2);
    end
    @(posedge clk); #1;
    ifu_icu_req_ic1 = 1'b0; resetn = 1'b1;
  endtask

  task automatic test_single();
    int t;
    fetch(32'h1C000004, 1'b1, 3, 0, 1'b0, t);
    checks++;
    if (t_mreq != t + 1) begin errors++; $display("FAIL mem_req_start: got cycle %0d, required %0d", t_mreq, t + 1); end
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if ({icu_ifu_data_ic2, icu_ifu_err_ic2} !== {32'hAAAA0001, 1'b0}) begin
      errors++; $display("FAIL data_hold: got %h/%b, required aaaa0001/0", icu_ifu_data_ic2, icu_ifu_err_ic2);
    end
  endtask

  task automatic test_stall();
    int a0, r0, c0, resp0, t1;
    bit got;
    gnt_dly = 3; rv_dly = 4; rerr_cfg = 1'b0;
    a0 = ack_cnt; r0 = mreq_rises; c0 = mreq_cycles; resp0 = resp_cnt; t1 = 0;
    exp_q.push_back({word_of(32'h1C000008), 1'b0});
    exp_addr_q.push_back(32'h1C000008);
    @(posedge clk); #1;
    ifu_icu_req_ic1 = 1'b1; ifu_icu_addr_ic1 = 32'h1C000008;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk); #1;
      if (icu_ifu_ack_ic1 === 1'b1) begin got = 1'b1; t1 = cyc; end
    end
    // Keep the request line high: the next request must wait for the response.
    @(posedge clk); #1;
    ifu_icu_addr_ic1 = 32'h1C000040;
    exp_q.push_back({word_of(32'h1C000040), 1'b0});
    exp_addr_q.push_back(32'h1C000040);
    got = 1'b0;
    for (int i = 0; i < 100 && !got; i++) begin
      if (resp_cnt != resp0) got = 1'b1;
      else begin @(negedge clk); #1; end
    end
    checks++;
    if (!got || t_dv - t1 != 10) begin errors++; $display("FAIL stall_latency: got %0d, required 10", t_dv - t1); end
    checks++;
    if (ack_cnt - a0 != 1) begin errors++; $display("FAIL stall_busy_ack: got %0d acks, required 1", ack_cnt - a0); end
    checks++;
    if (mreq_cycles - c0 != 4 || mreq_rises - r0 != 1) begin
      errors++; $display("FAIL stall_mem_req: got %0d cycles %0d rises, required 4 cycles 1 rise", mreq_cycles - c0, mreq_rises - r0);
    end
    @(negedge clk); #1;
    checks++;
    if (icu_ifu_ack_ic1 !== 1'b1) begin errors++; $display("FAIL stall_next_ack: got %b, required 1", icu_ifu_ack_ic1); end
    @(posedge clk); #1;
    ifu_icu_req_ic1 = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 100 && !got; i++) begin
      if (resp_cnt == resp0 + 2) got = 1'b1;
      else begin @(negedge clk); #1; end
    end
    checks++;
    if (!got || ack_cnt - a0 != 2) begin
      errors++; $display("FAIL stall_second: got %0d responses %0d acks, required 2/2", resp_cnt - resp0, ack_cnt - a0);
    end
    gnt_dly = 0; rv_dly = 0;
  endtask

  task automatic test_same_cycle();
    int t;
    same_cyc = 1'b1;
    fetch(32'h1C000084, 1'b1, 2, 0, 1'b0, t);
    same_cyc = 1'b0;
  endtask

  task automatic test_error();
    int t;
    fetch(32'h1C000100, 1'b1, 3, 0, 1'b1, t);
    fetch(32'h1C000104, 1'b1, 3, 0, 1'b0, t);
  endtask

  task automatic test_reset_wait();
    int r0, t;
    rv_dly = 30;
    exp_addr_q.push_back(32'h1C000300);
    @(posedge clk); #1;
    ifu_icu_req_ic1 = 1'b1; ifu_icu_addr_ic1 = 32'h1C000300;
    @(negedge clk); #1;
    checks++;
    if (icu_ifu_ack_ic1 !== 1'b1) begin errors++; $display("FAIL rst_wait_ack: got %b, required 1", icu_ifu_ack_ic1); end
    @(posedge clk); #1;
    ifu_icu_req_ic1 = 1'b0;
    @(posedge clk); #1;
    resetn = 1'b0;
    @(posedge clk); #1;
    resetn = 1'b1; rv_dly = 0; r0 = resp_cnt;
    @(negedge clk); #1;
    checks++;
    if ({icu_mem_req, icu_ifu_ack_ic1, icu_ifu_data_valid_ic2} !== 3'b000) begin
      errors++; $display("FAIL rst_wait_outputs: got req/ack/dv %b%b%b, required 000",
                         icu_mem_req, icu_ifu_ack_ic1, icu_ifu_data_valid_ic2);
    end
    // Reset while BUS: mem_req must drop the cycle after the reset edge.
    gnt_dly = 30;
    @(posedge clk); #1;
    ifu_icu_req_ic1 = 1'b1; ifu_icu_addr_ic1 = 32'h1C000310;
    @(posedge clk); #1;
    ifu_icu_req_ic1 = 1'b0;
    @(negedge clk); #1;
    checks++;
    if (icu_mem_req !== 1'b1) begin errors++; $display("FAIL rst_bus_req: got %b, required 1", icu_mem_req); end
    @(posedge clk); #1;
    resetn = 1'b0;
    @(posedge clk); #1;
    resetn = 1'b1; gnt_dly = 0;
    @(negedge clk); #1;
    checks++;
    if (icu_mem_req !== 1'b0) begin errors++; $display("FAIL rst_bus_drop: got %b, required 0", icu_mem_req); end
    inject_rv = 1'b1;
    repeat (4) @(negedge clk);
    #1;
    checks++;
    if (resp_cnt != r0) begin errors++; $display("FAIL late_rvalid: got %0d responses, required 0", resp_cnt - r0); end
    fetch(32'h1C000200, 1'b1, 3, 0, 1'b0, t);
  endtask

  task automatic test_back_to_back();
    int t, prev_dv;
    bit hit;
    for (int i = 0; i < 16; i++) begin
`ifdef C7BICU_LINEBUF_EN
      hit = (i % 2) == 1;
`else
      hit = 1'b0;
`endif
      prev_dv = t_dv;
      fetch(32'h1C000000 + 32'(i * 4), !hit, hit ? 1 : 3, 0, 1'b0, t);
      checks++;
      if (t != prev_dv + 1) begin
        errors++; $display("FAIL b2b_ack_%0d: got cycle %0d, required %0d", i, t, prev_dv + 1);
      end
    end
  endtask

  task automatic test_linebuf();
`ifdef C7BICU_LINEBUF_EN
    int t;
    fetch(32'h1C000000, 1'b1, 3, 0, 1'b0, t);
    fetch(32'h1C000004, 1'b0, 1, 0, 1'b0, t);
    @(posedge clk); #1;
    icu_inv = 1'b1;
    @(posedge clk); #1;
    icu_inv = 1'b0;
    fetch(32'h1C000004, 1'b1, 3, 0, 1'b0, t);
    fetch(32'h1C000000, 1'b1, 3, 1, 1'b0, t);
    fetch(32'h1C000004, 1'b1, 3, 0, 1'b0, t);
    fetch(32'h1C000000, 1'b0, 1, 0, 1'b0, t);
    fetch(32'h1C000008, 1'b1, 3, 2, 1'b0, t);
    fetch(32'h1C00000C, 1'b1, 3, 0, 1'b0, t);
`endif
  endtask

  initial begin
    test_reset();
    test_single();
    test_stall();
    test_same_cycle();
    test_error();
    test_reset_wait();
    test_back_to_back();
    test_linebuf();
    repeat (3) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL leftover_resp: got %0d pending, required 0", exp_q.size()); end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
